// File: rtl/run_sequencer.sv
// Program-run controller: holds the core in reset while Start is high, loads the PC
// on launch, runs until halt or watchdog, then acknowledges and steps to the next program.
module run_sequencer #(
    parameter int              PC_W       = 10,
    parameter int              CYC_W      = 16,
    parameter int              NPROG      = 3,
    parameter logic [CYC_W-1:0] MAX_CYCLES = 16'd60000,
    parameter logic [PC_W-1:0] PROG0_BASE = 10'd0,
    parameter logic [PC_W-1:0] PROG1_BASE = 10'd256,
    parameter logic [PC_W-1:0] PROG2_BASE = 10'd512,
    parameter logic [PC_W-1:0] PROG3_BASE = 10'd768
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             CoreHalt,
    output logic             CoreRst,
    output logic             CoreEn,
    output logic             PCLoad,
    output logic [PC_W-1:0]  PCLoadAddr,
    output logic [1:0]       ProgIdx,
    output logic [CYC_W-1:0] CycleCt,
    output logic             Timeout,
    output logic             Ack
);

    typedef enum logic [2:0] {IDLE, HOLD, LOAD, RUN, DONE} stateT;

    localparam logic [CYC_W-1:0] WD_LAST   = MAX_CYCLES - 1'b1;
    localparam logic [1:0]       LAST_PROG = 2'(NPROG - 1);

    stateT            state;
    stateT            stateNext;
    logic [1:0]       progIdxNext;
    logic [CYC_W-1:0] cycleCtNext;
    logic             timeoutNext;

    function automatic logic [PC_W-1:0] baseOf(input logic [1:0] idx);
        case (idx)
            2'd0:    baseOf = PROG0_BASE;
            2'd1:    baseOf = PROG1_BASE;
            2'd2:    baseOf = PROG2_BASE;
            default: baseOf = PROG3_BASE;
        endcase
    endfunction

    function automatic logic [1:0] advanceIdx(input logic [1:0] idx);
        advanceIdx = (idx == LAST_PROG) ? 2'd0 : idx + 2'd1;
    endfunction

    always_comb begin
        stateNext   = state;
        progIdxNext = ProgIdx;
        cycleCtNext = CycleCt;
        timeoutNext = Timeout;
        case (state)
            IDLE: if (Start) stateNext = HOLD;
            HOLD: if (!Start) stateNext = LOAD;
            LOAD: stateNext = Start ? HOLD : RUN;
            RUN: begin
                // Every RUN cycle counts, including the halting or watchdog one.
                cycleCtNext = CycleCt + 1'b1;
                if (Start) begin
                    stateNext = HOLD;
                end else if (CoreHalt) begin
                    stateNext   = DONE;
                    progIdxNext = advanceIdx(ProgIdx);
                    timeoutNext = 1'b0;
                end else if (CycleCt == WD_LAST) begin
                    stateNext   = DONE;
                    progIdxNext = advanceIdx(ProgIdx);
                    timeoutNext = 1'b1;
                end
            end
            DONE: if (Start) stateNext = HOLD;
            default: stateNext = IDLE;
        endcase
        if (stateNext == HOLD) begin
            cycleCtNext = '0;
            timeoutNext = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            CoreRst <= 1'b1;
            CoreEn  <= 1'b0;
            PCLoad  <= 1'b0;
            Ack     <= 1'b0;
            Timeout <= 1'b0;
            ProgIdx <= 2'd0;
            CycleCt <= '0;
        end else begin
            state   <= stateNext;
            CoreRst <= (stateNext == IDLE) || (stateNext == HOLD);
            CoreEn  <= (stateNext == RUN);
            PCLoad  <= (stateNext == LOAD);
            Ack     <= (stateNext == DONE);
            Timeout <= timeoutNext;
            ProgIdx <= progIdxNext;
            CycleCt <= cycleCtNext;
        end
    end

    // Load address is pure data: it simply tracks the registered program index.
    always_ff @(posedge Clk) begin
        PCLoadAddr <= baseOf(Reset ? progIdxNext : 2'd0);
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Program-run controller that sits between the bench handshake (Start/Ack) and the processor core (ProgCtr, RegFile, Ctrl). It holds the core in reset while Start is high and loads the PC with the base address of the current program when Start falls. It enables execution until the core's halt flag or a watchdog limit, then raises Ack. It also counts executed cycles and steps through up to four stored programs in order, wrapping back to the first.

## Interface
- PC_W, 10, width of PC load address.
- CYC_W, 16, width of cycle counter.
- NPROG, 3, number of programs (1..4); program index wraps at NPROG-1.
- MAX_CYCLES, 16'd60000, watchdog limit in RUN cycles; must be ≤ 2^CYC_W - 1.
- PROG0_BASE / PROG1_BASE / PROG2_BASE / PROG3_BASE, 10'd0 / 10'd256 / 10'd512 / 10'd768, InstROM start address per program.

Ports:
- Clk  in  1  clock, posedge only.
- Reset  in  1  synchronous, active-low reset, sampled at posedge Clk.
- Start  in  1  bench request; high = hold/prepare, high→low = launch.
- CoreHalt  in  1  done flag from Ctrl decoder; valid only while CoreEn=1.
- CoreRst  out  1  active-high reset to PC/RegFile.
- CoreEn  out  1  core advance enable; PC and register writes only when 1.
- PCLoad  out  1  one-cycle strobe: PC <= PCLoadAddr.
- PCLoadAddr  out  PC_W  base address of program ProgIdx.
- ProgIdx  out  2  current program number.
- CycleCt  out  CYC_W  RUN cycles of the current/last program.
- Timeout  out  1  last program ended by watchdog, not halt.
- Ack  out  1  program finished; held until next Start.

## Operation
- FSM states: IDLE, HOLD, LOAD, RUN, DONE. All outputs are registered, so decodes are Moore decodes of state plus registered counters.
- Reset low at a posedge: state=IDLE, CoreRst=1, CoreEn=0, PCLoad=0, Ack=0, Timeout=0, ProgIdx=0, CycleCt=0. Reset overrides every other input, including mid-RUN.
- IDLE: CoreRst=1. Start=1 → HOLD.
- HOLD: CoreRst=1, CoreEn=0, Ack=0, Timeout=0, CycleCt=0. Start=0 → LOAD.
- LOAD (exactly 1 cycle): CoreRst=0, PCLoad=1, PCLoadAddr=PROGn_BASE for n=ProgIdx, CoreEn=0.
  - Start=1 → HOLD.
  - Otherwise → RUN.
- RUN: CoreEn=1, CycleCt += 1 each cycle.
  - Start=1 → HOLD (abort). ProgIdx is unchanged and Ack stays 0.
  - CoreHalt=1 → DONE. The halting cycle is counted; ProgIdx advances.
  - CycleCt = MAX_CYCLES-1 with CoreHalt=0 → DONE, Timeout=1, ProgIdx advances.
  - If CoreHalt and the watchdog limit occur in the same cycle, halt wins: Timeout=0.
- ProgIdx advance: ProgIdx+1, wrapping NPROG-1 → 0.
- DONE: Ack=1, CoreEn=0, CoreRst=0. CycleCt and Timeout are frozen. Start=1 → HOLD (Ack drops on HOLD entry).
- Start held continuously high: the FSM stays in HOLD indefinitely. No launch without a high→low transition observed in HOLD.
- CycleCt never wraps; the watchdog bounds it at MAX_CYCLES.
- PCLoadAddr is driven from ProgIdx in every state and is meaningful only while PCLoad=1.

## Timing
- Start sampled low at edge k while in HOLD:
  - cycle k+1: LOAD, PCLoad=1.
  - cycle k+2: first RUN cycle, CoreEn=1, PC already at the base address.
- CoreHalt sampled high at edge m in RUN: DONE and Ack=1 from m+1. CoreEn=0 from m+1, so no instruction after the halt instruction commits.
- Start sampled high at edge j in IDLE/DONE/RUN/LOAD: HOLD from j+1, CoreRst=1 from j+1.
- Program of N instructions without branches, halting on the Nth: CycleCt=N at Ack.
- Reset has a 1-cycle effect: outputs take their reset values from the edge at which Reset is sampled low.

## Test plan
- Reset mid-RUN (Reset=0 for 1 edge with CycleCt=37) → next cycle CycleCt=0, ProgIdx=0, Ack=0, CoreRst=1, state IDLE.
- Basic launch: Start 1 for 3 cycles then 0; core halts on its 20th RUN cycle → PCLoad pulses once with PCLoadAddr=0, CoreEn high exactly 20 cycles, then Ack=1, CycleCt=20, Timeout=0, ProgIdx=1.
- Sequencing: three launches back to back → PCLoadAddr = 0, 256, 512; fourth launch uses 0 again (ProgIdx wraps 2→0).
- Watchdog: MAX_CYCLES=50, CoreHalt tied 0 → Ack after 50 RUN cycles, CycleCt=49→DONE with Timeout=1, ProgIdx advanced; next Start clears Timeout.
- Simultaneous events: CoreHalt=1 on the cycle CycleCt=MAX_CYCLES-1 → Timeout=0, Ack=1.
- Abort: Start raised at RUN cycle 10 → HOLD next cycle, Ack stays 0, ProgIdx unchanged. On relaunch the same PCLoadAddr is reloaded and CycleCt restarts from 0.
